// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code tracker: FSM state encoding and a
// width-agnostic Gray-to-binary helper.
package gray_pkg;

    localparam int unsigned GRAY_MAX_W = 64;

    typedef logic [0:0] state_t;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_TRACK = 1'b1;

    // Zero-extended input decodes correctly for any width <= GRAY_MAX_W,
    // because each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b = g;
        for (int unsigned i = 1; i < GRAY_MAX_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_to_binary.sv
// Purely combinational WIDTH-bit Gray-to-binary decoder.
// Ports:
//   gray  in   WIDTH  Gray-coded word
//   bin   out  WIDTH  binary decode (combinational)
module gray_to_binary
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    always_comb begin
        bin = WIDTH'(gray2bin(GRAY_MAX_W'(gray)));
    end

endmodule

// File: rtl/gray_to_binary_tracker.sv
// Samples a Gray-coded position word, decodes it, checks each sample for a
// legal single step against the previous one, tracks direction and keeps a
// signed multi-turn position count plus a saturating step-error count.
// Optional macro GRAY_SYNC_EN: gray_in and sample_en pass a 2-flop
// synchronizer stage first (latency 3 clk instead of 1).
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   clr         sync clear of position/err_cnt, FSM back to IDLE
//   gray_in     Gray-coded input word
//   sample_en   capture gray_in this cycle
//   bin_out     registered binary of last accepted sample
//   bin_valid   1-cycle pulse when bin_out updates
//   dir         last legal step direction (1=up)
//   step_err    1-cycle pulse on an illegal jump
//   position    signed accumulated step count (wraps)
//   err_cnt     saturating count of step errors
module gray_to_binary_tracker
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned POS_W = 16,
    parameter int unsigned ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             sample_en,
    output logic [WIDTH-1:0] bin_out,
    output logic             bin_valid,
    output logic             dir,
    output logic             step_err,
    output logic [POS_W-1:0] position,
    output logic [ERR_W-1:0] err_cnt
);

    logic [WIDTH-1:0] gray_s;
    logic             en_s;

`ifdef GRAY_SYNC_EN
    // Two-flop synchronizer; the enable travels alongside so it stays aligned.
    logic [WIDTH-1:0] gray_m;
    logic             en_m;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gray_m <= '0;
            gray_s <= '0;
            en_m   <= 1'b0;
            en_s   <= 1'b0;
        end else begin
            gray_m <= gray_in;
            gray_s <= gray_m;
            en_m   <= sample_en;
            en_s   <= en_m;
        end
    end
`else
    always_comb begin
        gray_s = gray_in;
        en_s   = sample_en;
    end
`endif

    logic [WIDTH-1:0] dec;
    logic [WIDTH-1:0] delta;

    gray_to_binary #(.WIDTH(WIDTH)) u_dec (
        .gray (gray_s),
        .bin  (dec)
    );

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] bin_d;
    logic             valid_d;
    logic             dir_d;
    logic             err_d;
    logic [POS_W-1:0] pos_d;
    logic [ERR_W-1:0] cnt_d;

    // Modular difference: +1 and -1 (all-ones) cover the wrap cases naturally.
    always_comb begin
        delta = dec - prev_q;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            prev_q    <= '0;
            bin_out   <= '0;
            bin_valid <= 1'b0;
            dir       <= 1'b0;
            step_err  <= 1'b0;
            position  <= '0;
            err_cnt   <= '0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            bin_out   <= bin_d;
            bin_valid <= valid_d;
            dir       <= dir_d;
            step_err  <= err_d;
            position  <= pos_d;
            err_cnt   <= cnt_d;
        end
    end

    // Next-state and next-output logic; clr wins over a coincident sample.
    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        bin_d   = bin_out;
        valid_d = 1'b0;
        dir_d   = dir;
        err_d   = 1'b0;
        pos_d   = position;
        cnt_d   = err_cnt;

        if (clr) begin
            state_d = ST_IDLE;
            pos_d   = '0;
            cnt_d   = '0;
        end else if (en_s) begin
            prev_d  = dec;
            bin_d   = dec;
            valid_d = 1'b1;
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_TRACK;
                end
                ST_TRACK: begin
                    if (delta == '0) begin
                        // repeated position: nothing to accumulate
                    end else if (delta == WIDTH'(1)) begin
                        pos_d = position + POS_W'(1);
                        dir_d = 1'b1;
                    end else if (delta == '1) begin
                        pos_d = position - POS_W'(1);
                        dir_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                        if (err_cnt != '1) begin
                            cnt_d = err_cnt + ERR_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

endmodule
